// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants and types for the multiplexed 7-segment driver.
//   GLYPH        : 16-entry hex glyph table, active-high, bit6 = g .. bit0 = a
//   SEG_OFF      : active-high pattern with every segment dark
//   slot_state_e : phase within one digit slot (BLANK guard, then DRIVE)
// -----------------------------------------------------------------------------
package seg7_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } slot_state_e;

    localparam logic [6:0] SEG_OFF = 7'h00;

    localparam logic [6:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
        7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
        7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
        7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
    };

endpackage

// File: rtl/seg7_glyph.sv
// -----------------------------------------------------------------------------
// seg7_glyph
// Combinational hex-to-segment decode.
//   nibble  : hex digit to display
//   blank   : 1 = force all segments off (suppressed leading zero)
//   pattern : active-high segments, bit6 = g .. bit0 = a
// -----------------------------------------------------------------------------
module seg7_glyph
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = GLYPH[nibble];
        if (blank) begin
            pattern = SEG_OFF;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed driver for an N-digit 7-segment bank.
//   clk, rst  : clock, synchronous active-high reset
//   value     : packed hex digits, digit 0 = bits [3:0]
//   load      : capture value/dp_in into the shadow registers
//   dp_in     : per-digit decimal point, 1 = lit
//   enable    : 0 = display dark and scan frozen
//   seg       : segments a..g (bit0 = a), polarity per ACTIVE_LOW
//   dp_out    : decimal point, polarity per ACTIVE_LOW
//   an        : one-hot digit select, polarity per ACTIVE_LOW
//   digit_idx : digit currently being scanned
// Each slot of REFRESH_DIV cycles starts with BLANK_CYCLES of all anodes off
// to stop the previous digit's pattern ghosting onto the next anode.
// Handshake: load is a single-cycle strobe with no back-pressure; it is
// always accepted on the edge where it is sampled high (rst = 0).
// -----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 50000,
    parameter int BLANK_CYCLES  = 500,
    parameter bit ACTIVE_LOW    = 1'b1,
    parameter bit BLANK_LEADING = 1'b1,
    localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    enable,
    output logic [6:0]              seg,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [IDX_W-1:0]        digit_idx
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]    LAST_CNT = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]    BLANK_C  = CW'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    // Idle (deasserted) levels on the pins
    localparam logic [6:0]            SEG_IDLE = ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
    localparam logic                  DP_IDLE  = ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_IDLE  = ACTIVE_LOW ? '1 : '0;

    logic [4*NUM_DIGITS-1:0] shadow_value;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [CW-1:0]           cnt;
    logic [3:0]              slot_nib;
    logic                    slot_dp;
    logic                    slot_blank;

    slot_state_e             slot_state;
    logic [3:0]              nibs [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   lead_zero;
    logic                    higher_zero;
    logic                    latch_now;
    logic [3:0]              eff_nib;
    logic                    eff_dp;
    logic                    eff_blank;
    logic [6:0]              glyph_pat;
    logic [NUM_DIGITS-1:0]   an_onehot;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_nib
        assign nibs[i] = shadow_value[4*i +: 4];
    end

    // Zero digits with only zeros above them are leading zeros; digit 0 is
    // always shown so an all-zero value reads "0".
    always_comb begin
        lead_zero   = '0;
        higher_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lead_zero[i] = higher_zero && (nibs[i] == 4'h0);
            higher_zero  = lead_zero[i];
        end
        lead_zero[0] = 1'b0;
    end

    assign slot_state = (cnt < BLANK_C) ? BLANK : DRIVE;

    // The slot register is loaded on the first DRIVE cycle. That same cycle
    // already has to produce the new digit in the output register, so the
    // decode path bypasses the slot register while latching. The bypass reads
    // the shadow registers as they stand before any same-cycle load.
    assign latch_now = enable && (cnt == BLANK_C);
    assign eff_nib   = latch_now ? nibs[digit_idx] : slot_nib;
    assign eff_dp    = latch_now ? shadow_dp[digit_idx] : slot_dp;
    assign eff_blank = latch_now ? (BLANK_LEADING && lead_zero[digit_idx]) : slot_blank;
    assign an_onehot = NUM_DIGITS'(1) << digit_idx;

    seg7_glyph u_glyph (
        .nibble  (eff_nib),
        .blank   (eff_blank),
        .pattern (glyph_pat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_value <= '0;
            shadow_dp    <= '0;
            cnt          <= '0;
            digit_idx    <= '0;
            slot_nib     <= 4'h0;
            slot_dp      <= 1'b0;
            slot_blank   <= 1'b0;
            seg          <= SEG_IDLE;
            dp_out       <= DP_IDLE;
            an           <= AN_IDLE;
        end else begin
            if (load) begin
                shadow_value <= value;
                shadow_dp    <= dp_in;
            end

            if (enable) begin
                if (cnt == LAST_CNT) begin
                    cnt       <= '0;
                    digit_idx <= (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            if (latch_now) begin
                slot_nib   <= eff_nib;
                slot_dp    <= eff_dp;
                slot_blank <= eff_blank;
            end

            if (!enable || slot_state == BLANK) begin
                seg    <= SEG_IDLE;
                dp_out <= DP_IDLE;
                an     <= AN_IDLE;
            end else begin
                seg    <= ACTIVE_LOW ? ~glyph_pat : glyph_pat;
                dp_out <= ACTIVE_LOW ? ~eff_dp : eff_dp;
                an     <= ACTIVE_LOW ? ~an_onehot : an_onehot;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Directed bench for seg7_scan_driver with NUM_DIGITS=4, REFRESH_DIV=8,
// BLANK_CYCLES=2, ACTIVE_LOW=1. Two instances share all inputs: dut uses
// BLANK_LEADING=1, dut_nb uses BLANK_LEADING=0.
// pos counts enabled cycles since the last reset release; slot = pos/8,
// cnt = pos%8, digit = slot%4.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int ND  = 4;
    localparam int DIV = 8;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   value = '0;
    logic          load = 1'b0;
    logic [3:0]    dp_in = '0;
    logic          enable = 1'b1;

    logic [6:0] seg, seg_nb;
    logic       dp_out, dp_out_nb;
    logic [3:0] an, an_nb;
    logic [1:0] digit_idx, digit_idx_nb;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS(ND), .REFRESH_DIV(DIV), .BLANK_CYCLES(2),
        .ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .value(value), .load(load), .dp_in(dp_in),
        .enable(enable), .seg(seg), .dp_out(dp_out), .an(an), .digit_idx(digit_idx)
    );

    seg7_scan_driver #(
        .NUM_DIGITS(ND), .REFRESH_DIV(DIV), .BLANK_CYCLES(2),
        .ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b0)
    ) dut_nb (
        .clk(clk), .rst(rst), .value(value), .load(load), .dp_in(dp_in),
        .enable(enable), .seg(seg_nb), .dp_out(dp_out_nb), .an(an_nb),
        .digit_idx(digit_idx_nb)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    int pos = 0;
    logic [11:0] exp_q[$];

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_pins(input string name, input logic [6:0] s, input logic d,
                            input logic [3:0] a);
        chk({name, ".seg"}, 16'(seg), 16'(s));
        chk({name, ".dp"},  16'(dp_out), 16'(d));
        chk({name, ".an"},  16'(an), 16'(a));
    endtask

    // ---------------- driver tasks ----------------
    // Advance one clock; inputs change and outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        if (!rst && enable) pos++;
        #1;
    endtask

    // Run until the current cycle is (digit k, cnt c), then one more edge so
    // the registered outputs show that cycle.
    task automatic goto_slot(input int k, input int c);
        int guard;
        guard = 0;
        do begin
            step();
            guard++;
        end while (!(((pos / DIV) % ND) == k && (pos % DIV) == c) && guard < 200);
        if (guard >= 200) begin
            n_checks++;
            n_errors++;
            $display("FAIL goto_timeout: got digit %0d cnt %0d required digit %0d cnt %0d",
                     (pos / DIV) % ND, pos % DIV, k, c);
        end
        step();
    endtask

    // Load, then resynchronise to the start of a frame so every digit's next
    // latch is strictly after the load.
    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        value = v;
        dp_in = d;
        load  = 1'b1;
        step();
        load  = 1'b0;
        goto_slot(3, 7);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [15:0] value;
        logic [3:0]  dp;
        int          digit;
        bit          nb;      // 1 = compare the BLANK_LEADING=0 instance
        logic [6:0]  seg;
        logic        dpo;
        logic [3:0]  an;
    } vec_t;

    vec_t vecs[$];

    initial begin
        // 12AF: F, A, 2, 1
        vecs.push_back('{16'h12AF, 4'h0, 0, 1'b0, 7'h0E, 1'b1, 4'hE});
        vecs.push_back('{16'h12AF, 4'h0, 1, 1'b0, 7'h08, 1'b1, 4'hD});
        vecs.push_back('{16'h12AF, 4'h0, 2, 1'b0, 7'h24, 1'b1, 4'hB});
        vecs.push_back('{16'h12AF, 4'h0, 3, 1'b0, 7'h79, 1'b1, 4'h7});
        // 0070 with dp on digit 0: two leading zeros blanked, anodes still on
        vecs.push_back('{16'h0070, 4'h1, 0, 1'b0, 7'h40, 1'b0, 4'hE});
        vecs.push_back('{16'h0070, 4'h1, 1, 1'b0, 7'h78, 1'b1, 4'hD});
        vecs.push_back('{16'h0070, 4'h1, 2, 1'b0, 7'h7F, 1'b1, 4'hB});
        vecs.push_back('{16'h0070, 4'h1, 3, 1'b0, 7'h7F, 1'b1, 4'h7});
        // C0D3 with dp on digit 2: inner zero is not a leading zero
        vecs.push_back('{16'hC0D3, 4'h4, 0, 1'b0, 7'h30, 1'b1, 4'hE});
        vecs.push_back('{16'hC0D3, 4'h4, 1, 1'b0, 7'h21, 1'b1, 4'hD});
        vecs.push_back('{16'hC0D3, 4'h4, 2, 1'b0, 7'h40, 1'b0, 4'hB});
        vecs.push_back('{16'hC0D3, 4'h4, 3, 1'b0, 7'h46, 1'b1, 4'h7});
        // 8000, dp on digit 3
        vecs.push_back('{16'h8000, 4'h8, 3, 1'b0, 7'h00, 1'b0, 4'h7});
        vecs.push_back('{16'h8000, 4'h8, 0, 1'b0, 7'h40, 1'b1, 4'hE});
        // 0000 with dp on digit 2: blank digit still shows its dp
        vecs.push_back('{16'h0000, 4'h4, 0, 1'b0, 7'h40, 1'b1, 4'hE});
        vecs.push_back('{16'h0000, 4'h4, 1, 1'b0, 7'h7F, 1'b1, 4'hD});
        vecs.push_back('{16'h0000, 4'h4, 2, 1'b0, 7'h7F, 1'b0, 4'hB});
        vecs.push_back('{16'h0000, 4'h4, 3, 1'b0, 7'h7F, 1'b1, 4'h7});
        // 0000 without leading-zero blanking: every digit reads 0
        vecs.push_back('{16'h0000, 4'h0, 0, 1'b1, 7'h40, 1'b1, 4'hE});
        vecs.push_back('{16'h0000, 4'h0, 1, 1'b1, 7'h40, 1'b1, 4'hD});
        vecs.push_back('{16'h0000, 4'h0, 2, 1'b1, 7'h40, 1'b1, 4'hB});
        vecs.push_back('{16'h0000, 4'h0, 3, 1'b1, 7'h40, 1'b1, 4'h7});
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [11:0] e;
        logic [11:0] got;

        // 1. reset, then reset reasserted mid-slot
        repeat (3) step();
        rst = 1'b0;
        repeat (12) step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_pins("reset_hold", 7'h7F, 1'b1, 4'hF);
            chk("reset_hold.idx", 16'(digit_idx), 16'd0);
            chk("reset_hold.cnt", 16'(dut.cnt), 16'd0);
        end
        pos = 0;
        rst = 1'b0;
        step();
        chk_pins("post_reset_c0", 7'h7F, 1'b1, 4'hF);
        step();
        chk_pins("post_reset_c1", 7'h7F, 1'b1, 4'hF);
        step();
        chk_pins("post_reset_c2", 7'h40, 1'b1, 4'hE);
        repeat (28) step();
        chk("wrap_pre.idx", 16'(digit_idx), 16'd3);
        step();
        chk("wrap_post.idx", 16'(digit_idx), 16'd0);

        // 2/3/6. table-driven digit patterns
        foreach (vecs[i]) begin
            do_load(vecs[i].value, vecs[i].dp);
            exp_q.push_back({vecs[i].an, vecs[i].dpo, vecs[i].seg});
            goto_slot(vecs[i].digit, 3);
            e = exp_q.pop_front();
            got = vecs[i].nb ? {an_nb, dp_out_nb, seg_nb} : {an, dp_out, seg};
            chk($sformatf("vec%0d.pins", i), 16'(got), 16'(e));
            chk($sformatf("vec%0d.idx", i),
                16'(vecs[i].nb ? digit_idx_nb : digit_idx), 16'(vecs[i].digit));
        end

        // blank guard at the start of a slot
        goto_slot(2, 1);
        chk_pins("guard_c1", 7'h7F, 1'b1, 4'hF);

        // 4. load mid-slot does not disturb the lit digit
        do_load(16'h12AF, 4'h0);
        goto_slot(1, 4);
        value = 16'h1111;
        load  = 1'b1;
        step();
        load  = 1'b0;
        chk_pins("midload_c5", 7'h08, 1'b1, 4'hD);
        step();
        step();
        chk_pins("midload_c7", 7'h08, 1'b1, 4'hD);
        step();
        chk_pins("midload_next_blank", 7'h7F, 1'b1, 4'hF);
        goto_slot(1, 2);
        chk_pins("midload_next_slot", 7'h79, 1'b1, 4'hD);

        // 5. enable drop mid-slot freezes the scan
        goto_slot(2, 3);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_pins("disabled", 7'h7F, 1'b1, 4'hF);
            chk("disabled.idx", 16'(digit_idx), 16'd2);
            chk("disabled.cnt", 16'(dut.cnt), 16'd4);
        end
        enable = 1'b1;
        step();
        chk_pins("resume_c4", 7'h79, 1'b1, 4'hB);
        chk("resume.cnt", 16'(dut.cnt), 16'd5);
        step();
        step();
        chk("resume_c7.idx", 16'(digit_idx), 16'd2);
        step();
        chk_pins("resume_c7", 7'h79, 1'b1, 4'hB);
        chk("resume_next.idx", 16'(digit_idx), 16'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL global_timeout: got time %0t required finish before it", $time);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $finish;
    end

endmodule
